// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI slave front-end of the single-port RAM
// subsystem: FSM state encoding and the 2-bit frame command codes.
// No ports.

package spi_ram_pkg;

   // state     | meaning
   // IDLE      | SS_n high or not yet seen low; nothing in progress
   // CHK_CMD   | sampling cmd[1] to pick the frame path
   // WRITE     | shifting in cmd[0] + payload of a write frame
   // READ_ADD  | shifting in a read frame while no read address is pending
   // READ_DATA | shifting in a read frame while a read address is pending
   // READ_WAIT | waiting for tx_valid from the RAM
   // READ_SEND | serialising the captured read word on MISO
   // HOLD      | frame finished; ignore MOSI until SS_n rises
   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA,
      READ_WAIT,
      READ_SEND,
      HOLD
   } state_t;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load serial shift register with selectable direction.
// MSB_FIRST=1 shifts toward the MSB (serial input enters at bit 0);
// MSB_FIRST=0 shifts toward the LSB (serial input enters at the top bit).
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   i_load        load i_load_data (takes priority over shift)
//   i_load_data   parallel load value
//   i_shift       shift one position, inserting i_ser_in
//   i_ser_in      serial input bit
//   o_par_next    register contents after one shift with i_ser_in; lets the
//                 owner capture a complete word on the same edge the last
//                 bit arrives, or drive the next outgoing bit from a register

module spi_shift_reg #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_data,
   input  logic             i_shift,
   input  logic             i_ser_in,
   output logic [WIDTH-1:0] o_par_next
);

   logic [WIDTH-1:0] r_data;

   always_comb begin
      if (MSB_FIRST) o_par_next = {r_data[WIDTH-2:0], i_ser_in};
      else           o_par_next = {i_ser_in, r_data[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n)       r_data <= '0;
      else if (i_load)  r_data <= i_load_data;
      else if (i_shift) r_data <= o_par_next;
   end

endmodule

// File: rtl/spi_slave_ram_if.sv
// SPI slave front-end for the single-port RAM. Deserialises
// {cmd[1:0], payload} frames from MOSI into rx_data/rx_valid and, for
// read-data commands, returns the RAM word on MISO. Also reports read
// sequence errors, frame aborts and busy.
// Ports:
//   clk, rst_n     SPI clock (rising edge), synchronous active-low reset
//   SS_n, MOSI     slave select (active low) and serial data in
//   tx_valid       RAM read data valid (only honoured in READ_WAIT)
//   tx_data        RAM read data
//   rx_data        {cmd, payload} of the last completed frame
//   rx_valid       one-cycle pulse, rx_data valid
//   MISO           serial data out, 0 when not sending
//   busy           high whenever not IDLE
//   rd_seq_err     one-cycle pulse, read-data command without pending address
//   frame_abort    one-cycle pulse, SS_n rose mid-frame or mid-reply

module spi_slave_ram_if
   import spi_ram_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   output logic              MISO,
   output logic              busy,
   output logic              rd_seq_err,
   output logic              frame_abort
);

   localparam int CNT_W = $clog2(DATA_W + 2);
   // Down-counter start values; terminal count is zero in both directions.
   localparam logic [CNT_W-1:0] RX_START = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] TX_START = CNT_W'(DATA_W - 1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_cmd_hi;
   logic              r_cmd_lo;
   logic              r_rd_addr_done;
   logic [DATA_W+1:0] r_rx_data;
   logic              r_rx_valid;
   logic              r_miso;
   logic              r_rd_seq_err;
   logic              r_frame_abort;

   logic              w_in_rx;
   logic              w_rx_shift;
   logic              w_tx_load;
   logic              w_tx_shift;
   logic [1:0]        w_cmd;
   logic [DATA_W-1:0] w_rx_next;
   logic [DATA_W-1:0] w_tx_next;
   logic              w_tx_first_bit;
   logic              w_tx_next_bit;

   assign w_in_rx    = (r_state == WRITE) || (r_state == READ_ADD) ||
                       (r_state == READ_DATA);
   // The first edge in an RX state carries cmd[0], which is kept apart from
   // the payload so payload bit order never affects the command bits.
   assign w_rx_shift = w_in_rx && !SS_n && (r_cnt != RX_START);
   assign w_tx_load  = (r_state == READ_WAIT) && !SS_n && tx_valid;
   assign w_tx_shift = (r_state == READ_SEND) && !SS_n && (r_cnt != '0);
   assign w_cmd      = {r_cmd_hi, r_cmd_lo};

   assign w_tx_first_bit = MSB_FIRST ? tx_data[DATA_W-1]   : tx_data[0];
   assign w_tx_next_bit  = MSB_FIRST ? w_tx_next[DATA_W-1] : w_tx_next[0];

   spi_shift_reg #(
      .WIDTH     (DATA_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_rx_shift (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (1'b0),
      .i_load_data ('0),
      .i_shift     (w_rx_shift),
      .i_ser_in    (MOSI),
      .o_par_next  (w_rx_next)
   );

   spi_shift_reg #(
      .WIDTH     (DATA_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_tx_shift (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_tx_load),
      .i_load_data (tx_data),
      .i_shift     (w_tx_shift),
      .i_ser_in    (1'b0),
      .o_par_next  (w_tx_next)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_cnt          <= '0;
         r_cmd_hi       <= 1'b0;
         r_cmd_lo       <= 1'b0;
         r_rd_addr_done <= 1'b0;
         r_rx_data      <= '0;
         r_rx_valid     <= 1'b0;
         r_miso         <= 1'b0;
         r_rd_seq_err   <= 1'b0;
         r_frame_abort  <= 1'b0;
      end else begin
         r_rx_valid    <= 1'b0;
         r_rd_seq_err  <= 1'b0;
         r_frame_abort <= 1'b0;

         if (SS_n && (r_state != IDLE) && (r_state != HOLD)) begin
            // rd_addr_done is left alone so an aborted read can be retried.
            r_frame_abort <= 1'b1;
            r_miso        <= 1'b0;
            r_state       <= IDLE;
         end else begin
            case (r_state)
               IDLE: begin
                  if (!SS_n) r_state <= CHK_CMD;
               end

               CHK_CMD: begin
                  r_cmd_hi <= MOSI;
                  r_cnt    <= RX_START;
                  if (!MOSI)               r_state <= WRITE;
                  else if (r_rd_addr_done) r_state <= READ_DATA;
                  else                     r_state <= READ_ADD;
               end

               WRITE, READ_ADD, READ_DATA: begin
                  if (r_cnt == RX_START) begin
                     r_cmd_lo <= MOSI;
                     r_cnt    <= r_cnt - 1'b1;
                  end else if (r_cnt != '0) begin
                     r_cnt <= r_cnt - 1'b1;
                  end else begin
                     r_rx_data <= {w_cmd, w_rx_next};
                     r_state   <= HOLD;
                     if (r_state == WRITE) begin
                        r_rx_valid <= 1'b1;
                     end else if (r_state == READ_ADD) begin
                        if (w_cmd == CMD_RD_DATA) begin
                           r_rd_seq_err <= 1'b1;
                        end else begin
                           r_rx_valid     <= 1'b1;
                           r_rd_addr_done <= 1'b1;
                        end
                     end else begin
                        r_rx_valid <= 1'b1;
                        if (w_cmd == CMD_RD_DATA) r_state <= READ_WAIT;
                     end
                  end
               end

               READ_WAIT: begin
                  if (tx_valid) begin
                     r_miso  <= w_tx_first_bit;
                     r_cnt   <= TX_START;
                     r_state <= READ_SEND;
                  end
               end

               READ_SEND: begin
                  if (r_cnt == '0) begin
                     r_miso         <= 1'b0;
                     r_rd_addr_done <= 1'b0;
                     r_state        <= HOLD;
                  end else begin
                     r_miso <= w_tx_next_bit;
                     r_cnt  <= r_cnt - 1'b1;
                  end
               end

               HOLD: begin
                  if (SS_n) r_state <= IDLE;
               end

               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign MISO        = r_miso;
   assign busy        = (r_state != IDLE);
   assign rd_seq_err  = r_rd_seq_err;
   assign frame_abort = r_frame_abort;

endmodule

// File: tb/tb_spi_slave_ram_if.sv
// Bench for spi_slave_ram_if: one 8-bit MSB-first instance and one 16-bit
// LSB-first instance share the clock; 'sel' routes stimulus to one of them
// while the other sees SS_n high. Expected results come from a frame-level
// model (pending read address flag per instance, {cmd,payload} arithmetic,
// reply bit order from the parameter).

module tb_spi_slave_ram_if;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel;
   logic        SS_n;
   logic        MOSI;
   logic        tx_valid;
   logic [15:0] tx_data;

   logic        ss_a, ss_b, txv_a, txv_b;
   logic [9:0]  rx_data_a;
   logic [17:0] rx_data_b;
   logic        rx_valid_a, miso_a, busy_a, seq_a, abort_a;
   logic        rx_valid_b, miso_b, busy_b, seq_b, abort_b;

   logic [31:0] o_rx;
   logic        o_rxv, o_miso, o_busy, o_seq, o_abort;

   int total = 0;
   int bad   = 0;

   int          edge_n = 0;
   int          n_rxv, n_seq, n_abort, n_miso_bad, rxv_edge;
   logic [31:0] last_rx;
   bit          in_reply;
   bit          pending [2];

   always #5 clk = ~clk;

   assign ss_a  = sel ? 1'b1 : SS_n;
   assign ss_b  = sel ? SS_n : 1'b1;
   assign txv_a = sel ? 1'b0 : tx_valid;
   assign txv_b = sel ? tx_valid : 1'b0;

   assign o_rx    = sel ? {14'b0, rx_data_b} : {22'b0, rx_data_a};
   assign o_rxv   = sel ? rx_valid_b : rx_valid_a;
   assign o_miso  = sel ? miso_b     : miso_a;
   assign o_busy  = sel ? busy_b     : busy_a;
   assign o_seq   = sel ? seq_b      : seq_a;
   assign o_abort = sel ? abort_b    : abort_a;

   spi_slave_ram_if #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .SS_n(ss_a), .MOSI(MOSI),
      .tx_valid(txv_a), .tx_data(tx_data[7:0]),
      .rx_data(rx_data_a), .rx_valid(rx_valid_a), .MISO(miso_a),
      .busy(busy_a), .rd_seq_err(seq_a), .frame_abort(abort_a)
   );

   spi_slave_ram_if #(.DATA_W(16), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .SS_n(ss_b), .MOSI(MOSI),
      .tx_valid(txv_b), .tx_data(tx_data),
      .rx_data(rx_data_b), .rx_valid(rx_valid_b), .MISO(miso_b),
      .busy(busy_b), .rd_seq_err(seq_b), .frame_abort(abort_b)
   );

   // One clock edge, then observe the selected instance 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
      edge_n++;
      if (o_rxv) begin
         n_rxv++;
         last_rx  = o_rx;
         rxv_edge = edge_n;
      end
      if (o_seq)   n_seq++;
      if (o_abort) n_abort++;
      if (!in_reply && o_miso) n_miso_bad++;
   endtask

   // Drives one frame on the selected instance and checks it against the
   // frame-level model. nbits < W+2 aborts after that many bits; dly < 0
   // aborts while waiting for tx_valid; rst_at >= 0 resets after that many
   // reply bits have been observed.
   task automatic send_frame(input logic [1:0] cmd, input logic [31:0] pay,
                             input int nbits, input logic [15:0] rdat,
                             input int dly, input int rst_at);
      int          w, e0, extra;
      bit          msb, reply;
      logic [31:0] mask, exp_rx, got_seq, exp_seq;
      w     = sel ? 16 : 8;
      msb   = (sel == 1'b0);
      mask  = (32'd1 << w) - 32'd1;
      n_rxv = 0; n_seq = 0; n_abort = 0; n_miso_bad = 0; in_reply = 0;

      tx_valid = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
      step();
      total++;
      if (o_busy !== 1'b0) begin
         bad++; $display("FAIL idle_busy: got %b want 0", o_busy);
      end

      SS_n = 1'b0;
      step();
      e0 = edge_n;
      for (int i = 0; i < nbits; i++) begin
         if (i == 0)      MOSI = cmd[1];
         else if (i == 1) MOSI = cmd[0];
         else if (msb)    MOSI = pay[w+1-i];
         else             MOSI = pay[i-2];
         tx_valid = 1'($urandom);
         tx_data  = 16'($urandom);
         step();
      end
      tx_valid = 1'b0;

      if (nbits < w + 2) begin
         SS_n = 1'b1;
         step();
         total++;
         if (n_abort !== 1 || n_rxv !== 0 || n_miso_bad !== 0) begin
            bad++;
            $display("FAIL frame_abort: got aborts=%0d rx=%0d miso_hi=%0d want 1 0 0 (bits=%0d)",
                     n_abort, n_rxv, n_miso_bad, nbits);
         end
         return;
      end

      reply  = (cmd == 2'b11) && pending[sel];
      exp_rx = (32'(cmd) << w) | (pay & mask);
      if (!reply) begin
         extra = $urandom_range(0, 2);
         for (int k = 0; k < extra; k++) begin
            MOSI = 1'($urandom);
            step();
         end
      end

      if (cmd == 2'b11 && !pending[sel]) begin
         total++;
         if (n_seq !== 1 || n_rxv !== 0) begin
            bad++;
            $display("FAIL rd_seq_err: got err=%0d rx=%0d want 1 0", n_seq, n_rxv);
         end
      end else begin
         total++;
         if (n_rxv !== 1 || last_rx !== exp_rx) begin
            bad++;
            $display("FAIL rx_word: got n=%0d data=%0h want n=1 data=%0h", n_rxv, last_rx, exp_rx);
         end
         total++;
         if (rxv_edge - e0 !== w + 2) begin
            bad++;
            $display("FAIL rx_latency: got %0d want %0d", rxv_edge - e0, w + 2);
         end
      end
      if (cmd == 2'b10) pending[sel] = 1'b1;

      if (!reply) begin
         total++;
         if (n_miso_bad !== 0 || n_abort !== 0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL hold_state: got miso_hi=%0d aborts=%0d busy=%b want 0 0 1",
                     n_miso_bad, n_abort, o_busy);
         end
         return;
      end

      if (dly < 0) begin
         MOSI = 1'($urandom);
         step();
         SS_n = 1'b1;
         step();
         total++;
         if (n_abort !== 1 || o_miso !== 1'b0 || n_miso_bad !== 0) begin
            bad++;
            $display("FAIL wait_abort: got aborts=%0d miso=%b want 1 0", n_abort, o_miso);
         end
         return;
      end

      for (int k = 0; k < dly; k++) begin
         MOSI = 1'($urandom);
         step();
      end
      total++;
      if (o_busy !== 1'b1 || n_miso_bad !== 0) begin
         bad++;
         $display("FAIL read_wait: got busy=%b miso_hi=%0d want 1 0", o_busy, n_miso_bad);
      end

      tx_data  = rdat;
      tx_valid = 1'b1;
      in_reply = 1'b1;
      step();
      tx_data  = 16'($urandom);
      got_seq  = '0;
      exp_seq  = '0;
      for (int k = 0; k < w; k++) begin
         if (k == rst_at) begin
            rst_n    = 1'b0;
            in_reply = 1'b0;
            tx_valid = 1'b0;
            step();
            total++;
            if ({o_rx, o_rxv, o_miso, o_busy, o_seq, o_abort} !== '0) begin
               bad++;
               $display("FAIL reset_mid_send: got rx=%0h v=%b miso=%b busy=%b err=%b abort=%b want all 0",
                        o_rx, o_rxv, o_miso, o_busy, o_seq, o_abort);
            end
            rst_n      = 1'b1;
            pending[0] = 1'b0;
            pending[1] = 1'b0;
            return;
         end
         got_seq = (got_seq << 1) | 32'(o_miso);
         exp_seq = (exp_seq << 1) | 32'(msb ? rdat[w-1-k] : rdat[k]);
         tx_valid = 1'($urandom);
         if (k < w - 1) step();
      end
      tx_valid = 1'b0;
      total++;
      if (got_seq !== exp_seq) begin
         bad++;
         $display("FAIL miso_bits: got %0h want %0h", got_seq, exp_seq);
      end

      in_reply = 1'b0;
      step();
      total++;
      if (o_miso !== 1'b0 || o_busy !== 1'b1 || n_abort !== 0) begin
         bad++;
         $display("FAIL reply_end: got miso=%b busy=%b aborts=%0d want 0 1 0", o_miso, o_busy, n_abort);
      end
      pending[sel] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
      step();
      step();
      total++;
      if ({rx_data_a, rx_valid_a, miso_a, busy_a, seq_a, abort_a} !== '0) begin
         bad++;
         $display("FAIL reset_a: got rx=%0h v=%b miso=%b busy=%b err=%b abort=%b want all 0",
                  rx_data_a, rx_valid_a, miso_a, busy_a, seq_a, abort_a);
      end
      total++;
      if ({rx_data_b, rx_valid_b, miso_b, busy_b, seq_b, abort_b} !== '0) begin
         bad++;
         $display("FAIL reset_b: got rx=%0h v=%b miso=%b busy=%b err=%b abort=%b want all 0",
                  rx_data_b, rx_valid_b, miso_b, busy_b, seq_b, abort_b);
      end
      rst_n      = 1'b1;
      pending[0] = 1'b0;
      pending[1] = 1'b0;
   endtask

   task automatic test_basic_frames();
      sel = 1'b0;
      send_frame(2'b00, 32'hA5, 10, 16'h0, 0, -1);
      send_frame(2'b01, 32'h3C, 10, 16'h0, 0, -1);
      send_frame(2'b10, 32'h12, 10, 16'h0, 0, -1);
      send_frame(2'b11, 32'h00, 10, 16'hC3, 2, -1);
      send_frame(2'b11, 32'h5A, 10, 16'h0, 0, -1);
   endtask

   task automatic test_seq_err_after_reset();
      sel = 1'b0;
      test_reset();
      send_frame(2'b11, 32'hFF, 10, 16'h0, 0, -1);
   endtask

   task automatic test_abort();
      sel = 1'b0;
      send_frame(2'b00, 32'h77, 5, 16'h0, 0, -1);
      send_frame(2'b00, 32'h01, 10, 16'h0, 0, -1);
      send_frame(2'b01, 32'hEE, 9, 16'h0, 0, -1);
      send_frame(2'b10, 32'h40, 10, 16'h0, 0, -1);
      send_frame(2'b11, 32'h00, 10, 16'h0, -1, -1);
      send_frame(2'b11, 32'h00, 10, 16'h96, 1, -1);
   endtask

   task automatic test_reset_mid_send();
      sel = 1'b0;
      send_frame(2'b10, 32'h33, 10, 16'h0, 0, -1);
      send_frame(2'b11, 32'h00, 10, 16'hFF, 0, 3);
      send_frame(2'b11, 32'h00, 10, 16'h0, 0, -1);
   endtask

   task automatic test_lsb_first();
      sel = 1'b1;
      send_frame(2'b00, 32'h1234, 18, 16'h0, 0, -1);
      send_frame(2'b10, 32'hBEEF, 18, 16'h0, 0, -1);
      send_frame(2'b11, 32'h0000, 18, 16'h8001, 0, -1);
   endtask

   task automatic test_random();
      int          w, nbits, dly, rst_at;
      logic [1:0]  cmd;
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         w   = sel ? 16 : 8;
         for (int n = 0; n < 50; n++) begin
            cmd    = 2'($urandom);
            nbits  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, w + 1) : w + 2;
            dly    = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 3);
            rst_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, w - 1) : -1;
            send_frame(cmd, $urandom, nbits, 16'($urandom), dly, rst_at);
         end
      end
   endtask

   initial begin
      sel = 1'b0;
      in_reply = 1'b0;
      test_reset();
      test_basic_frames();
      test_seq_err_after_reset();
      test_abort();
      test_reset_mid_send();
      test_lsb_first();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
